mem_stage_sram_ctrl: RTL and testbench

Memory stage of the ARM pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its ALU result (address), Rm value (store data) and memory read/write enables. It performs 32-bit word loads and stores to an external 16-bit asynchronous SRAM as two half-word accesses, each with configurable wait states. It asserts freeze to stall the pipeline until each access completes.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 30 +++
 rtl/mem_stage_sram_ctrl_if.sv | 28 ++
 rtl/mem_stage_sram_ctrl_sram_wait_counter.sv | 34 +++
 rtl/mem_stage_sram_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared widths, state encoding and address mapping for the SRAM memory stage
package mem_stage_sram_ctrl_pkg;

    localparam int REGISTER_LEN  = 32;
    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int WORD_ADDR_LEN = SRAM_ADDR_LEN - 1;

    localparam logic [REGISTER_LEN-1:0] BASE_ADDR_DEF = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_LO = 3'd1,
        ST_WR_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_RD_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Byte address to 32-bit SRAM word index; wraps silently outside the SRAM window.
    function automatic logic [WORD_ADDR_LEN-1:0] sram_word(
        input logic [REGISTER_LEN-1:0] byte_addr,
        input logic [REGISTER_LEN-1:0] base
    );
        logic [REGISTER_LEN-1:0] offset;
        offset = byte_addr - base;
        return WORD_ADDR_LEN'(offset >> 2);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - pipeline request and SRAM pin bundle for the memory stage
interface mem_stage_sram_ctrl_if;
    import mem_stage_sram_ctrl_pkg::*;

    logic                     mem_r_en;
    logic                     mem_w_en;
    logic [REGISTER_LEN-1:0]  alu_res;
    logic [REGISTER_LEN-1:0]  val_Rm;
    logic [REGISTER_LEN-1:0]  mem_rdata;
    logic                     ready;
    logic                     freeze;
    logic [SRAM_ADDR_LEN-1:0] sram_addr;
    logic [SRAM_DATA_LEN-1:0] sram_dq_out;
    logic                     sram_dq_oe;
    logic [SRAM_DATA_LEN-1:0] sram_dq_in;
    logic                     sram_we_n;

    modport master (
        output mem_r_en, mem_w_en, alu_res, val_Rm, sram_dq_in,
        input  mem_rdata, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_res, val_Rm, sram_dq_in,
        output mem_rdata, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// rtl/mem_stage_sram_ctrl_sram_wait_counter.sv - times each half-word phase to WAIT_CYCLES+1 cycles
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic phase_done_o
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_done_o = en_i && (cnt_q == LAST);

    // Dropping en_i or finishing a phase clears the count so the next phase starts at zero.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || phase_done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - pipeline memory stage: 32-bit loads/stores as two 16-bit async SRAM accesses
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int                      WAIT_CYCLES = 1,
    parameter logic [REGISTER_LEN-1:0] BASE_ADDR   = BASE_ADDR_DEF
) (
    input logic                  clk,
    input logic                  rst,
    mem_stage_sram_ctrl_if.slave bus
);

    state_e                   state_q, state_d;
    logic [WORD_ADDR_LEN-1:0] word_q, word_d;
    logic [REGISTER_LEN-1:0]  wdata_q, wdata_d;
    logic [REGISTER_LEN-1:0]  rdata_q, rdata_d;
    logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
    logic [SRAM_DATA_LEN-1:0] dq_q, dq_d;
    logic                     oe_q, oe_d;
    logic                     we_n_q, we_n_d;
    logic                     in_phase;
    logic                     phase_done;
    logic                     accept;

    assign in_phase = state_q inside {ST_WR_LO, ST_WR_HI, ST_RD_LO, ST_RD_HI};
    assign accept   = (state_q == ST_IDLE) && (bus.mem_w_en || bus.mem_r_en);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk         (clk),
        .rst         (rst),
        .en_i        (in_phase),
        .phase_done_o(phase_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    // A simultaneous read and write request is treated as a write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_w_en) begin
                    state_d = ST_WR_LO;
                end else if (bus.mem_r_en) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_WR_LO: if (phase_done) state_d = ST_WR_HI;
            ST_WR_HI: if (phase_done) state_d = ST_DONE;
            ST_RD_LO: if (phase_done) state_d = ST_RD_HI;
            ST_RD_HI: if (phase_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are registered from the next state so they are stable for the whole phase.
    always_comb begin
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        oe_d    = 1'b0;
        we_n_d  = 1'b1;

        if (accept) begin
            word_d = sram_word(bus.alu_res, BASE_ADDR);
            if (bus.mem_w_en) begin
                wdata_d = bus.val_Rm;
            end
        end

        if (phase_done && state_q == ST_RD_LO) begin
            rdata_d[SRAM_DATA_LEN-1:0] = bus.sram_dq_in;
        end
        if (phase_done && state_q == ST_RD_HI) begin
            rdata_d[REGISTER_LEN-1:SRAM_DATA_LEN] = bus.sram_dq_in;
        end

        case (state_d)
            ST_WR_LO: begin
                addr_d = {word_d, 1'b0};
                dq_d   = wdata_d[SRAM_DATA_LEN-1:0];
                oe_d   = 1'b1;
                we_n_d = 1'b0;
            end
            ST_WR_HI: begin
                addr_d = {word_d, 1'b1};
                dq_d   = wdata_d[REGISTER_LEN-1:SRAM_DATA_LEN];
                oe_d   = 1'b1;
                we_n_d = 1'b0;
            end
            ST_RD_LO: addr_d = {word_d, 1'b0};
            ST_RD_HI: addr_d = {word_d, 1'b1};
            default: ;
        endcase
    end

    assign bus.mem_rdata   = rdata_q;
    assign bus.ready       = (state_q == ST_DONE);
    assign bus.freeze      = (bus.mem_r_en || bus.mem_w_en) && (state_q != ST_DONE);
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - self-checking bench for mem_stage_sram_ctrl at WAIT_CYCLES 1 and 0
module tb_mem_stage_sram_ctrl;
    import mem_stage_sram_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_fast;
    logic        r_en, w_en;
    logic [31:0] alu, rm;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;
    bit          dev_init_done = 1'b0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if bus_slow ();
    mem_stage_sram_ctrl_if bus_fast ();

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_slow (
        .clk(clk), .rst(rst), .bus(bus_slow)
    );
    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_fast (
        .clk(clk), .rst(rst), .bus(bus_fast)
    );

    assign bus_slow.mem_r_en = !sel_fast && r_en;
    assign bus_slow.mem_w_en = !sel_fast && w_en;
    assign bus_slow.alu_res  = alu;
    assign bus_slow.val_Rm   = rm;
    assign bus_fast.mem_r_en = sel_fast && r_en;
    assign bus_fast.mem_w_en = sel_fast && w_en;
    assign bus_fast.alu_res  = alu;
    assign bus_fast.val_Rm   = rm;

    logic [15:0] dev_slow [0:262143];
    logic [15:0] dev_fast [0:262143];

    assign bus_slow.sram_dq_in = dev_slow[bus_slow.sram_addr];
    assign bus_fast.sram_dq_in = dev_fast[bus_fast.sram_addr];

    function automatic logic [15:0] init_val(input int a);
        return 16'(a) ^ 16'h5A3C;
    endfunction

    // Asynchronous SRAM devices: preset contents, then latch write data while we_n is low.
    always @(negedge clk) begin
        if (!dev_init_done) begin
            for (int i = 0; i < 262144; i++) begin
                dev_slow[i] <= init_val(i);
                dev_fast[i] <= init_val(i);
            end
            dev_init_done <= 1'b1;
        end else begin
            if (!bus_slow.sram_we_n) dev_slow[bus_slow.sram_addr] <= bus_slow.sram_dq_out;
            if (!bus_fast.sram_we_n) dev_fast[bus_fast.sram_addr] <= bus_fast.sram_dq_out;
        end
    end

    logic        mon_ready, mon_freeze, mon_we_n, mon_oe;
    logic [17:0] mon_addr;
    logic [15:0] mon_dq;
    logic [31:0] mon_rdata;

    always_comb begin
        mon_ready  = sel_fast ? bus_fast.ready       : bus_slow.ready;
        mon_freeze = sel_fast ? bus_fast.freeze      : bus_slow.freeze;
        mon_we_n   = sel_fast ? bus_fast.sram_we_n   : bus_slow.sram_we_n;
        mon_oe     = sel_fast ? bus_fast.sram_dq_oe  : bus_slow.sram_dq_oe;
        mon_addr   = sel_fast ? bus_fast.sram_addr   : bus_slow.sram_addr;
        mon_dq     = sel_fast ? bus_fast.sram_dq_out : bus_slow.sram_dq_out;
        mon_rdata  = sel_fast ? bus_fast.mem_rdata   : bus_slow.mem_rdata;
    end

    logic [15:0] ref_mem [int];

    function automatic int key(input logic [17:0] a);
        return int'({sel_fast, a});
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        if (ref_mem.exists(key(a))) return ref_mem[key(a)];
        return init_val(int'(a));
    endfunction

    function automatic logic [15:0] dev_rd(input logic [17:0] a);
        return sel_fast ? dev_fast[a] : dev_slow[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        w_en = 1'b0;
        r_en = 1'b0;
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            chk("idle_ready", mon_ready, 0);
            chk("idle_freeze", mon_freeze, 0);
            chk("idle_we_n", mon_we_n, 1);
            chk("idle_oe", mon_oe, 0);
            next_cycle();
        end
    endtask

    // One access from acceptance to the ready cycle; inputs are scrambled once latched.
    task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int          n, last;
        logic [16:0] word;
        logic [17:0] lo, hi_a;
        bit          in_ph, hi;
        n     = sel_fast ? 1 : 2;
        last  = 2 * n + 1;
        word  = 17'((a - BASE) >> 2);
        lo    = {word, 1'b0};
        hi_a  = {word, 1'b1};
        w_en  = w;
        r_en  = r;
        alu   = a;
        rm    = d;
        if (!w && r) exp_rdata = {ref_rd(hi_a), ref_rd(lo)};
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            in_ph = (c >= 1) && (c < last);
            hi    = (c > n);
            chk("ready", mon_ready, (c == last));
            chk("freeze", mon_freeze, (c < last));
            chk("we_n", mon_we_n, !(in_ph && w));
            chk("dq_oe", mon_oe, (in_ph && w));
            if (in_ph) begin
                chk("sram_addr", mon_addr, hi ? hi_a : lo);
                if (w) chk("dq_out", mon_dq, hi ? d[31:16] : d[15:0]);
            end
            if (c == last) chk("mem_rdata", mon_rdata, exp_rdata);
            next_cycle();
            if (c == 0) begin
                alu = $urandom();
                rm  = $urandom();
            end
        end
        if (w) begin
            ref_mem[key(lo)]   = d[15:0];
            ref_mem[key(hi_a)] = d[31:16];
            chk("dev_lo", dev_rd(lo), ref_rd(lo));
            chk("dev_hi", dev_rd(hi_a), ref_rd(hi_a));
        end
    endtask

    task automatic rand_ops(input int count);
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            kind = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) a = $urandom();
            else a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            do_op(kind <= 3 || kind == 7, kind >= 4, a, $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        rst       = 1'b1;
        sel_fast  = 1'b0;
        w_en      = 1'b0;
        r_en      = 1'b0;
        alu       = 32'd0;
        rm        = 32'd0;
        exp_rdata = 32'd0;
        repeat (3) next_cycle();
        for (int s = 0; s < 2; s++) begin
            sel_fast = s[0];
            @(negedge clk);
            chk("rst_rdata", mon_rdata, 0);
            chk("rst_addr", mon_addr, 0);
            chk("rst_dq", mon_dq, 0);
            chk("rst_oe", mon_oe, 0);
            chk("rst_we_n", mon_we_n, 1);
            chk("rst_ready", mon_ready, 0);
            chk("rst_freeze", mon_freeze, 0);
        end
        sel_fast = 1'b0;
        next_cycle();
        rst = 1'b0;

        idle(10);
        do_op(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        do_op(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("plan_load", exp_rdata, 32'hDEADBEEF);
        do_op(1'b1, 1'b1, 32'd1024, 32'h12345678);
        idle(2);

        // Reset lands on the first high-half cycle of a store.
        w_en = 1'b1;
        r_en = 1'b0;
        alu  = 32'd1040;
        rm   = 32'hCAFEF00D;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk("abort_freeze", mon_freeze, 1);
            if (c < 3) next_cycle();
        end
        chk("abort_addr_hi", mon_addr, 18'd9);
        rst  = 1'b1;
        w_en = 1'b0;
        next_cycle();
        rst = 1'b0;
        ref_mem[key(18'd8)] = 16'hF00D;
        ref_mem[key(18'd9)] = 16'hCAFE;
        exp_rdata = 32'd0;
        @(negedge clk);
        chk("abort_we_n", mon_we_n, 1);
        chk("abort_oe", mon_oe, 0);
        chk("abort_addr", mon_addr, 0);
        chk("abort_dq", mon_dq, 0);
        chk("abort_rdata", mon_rdata, 0);
        chk("abort_ready", mon_ready, 0);
        next_cycle();
        idle(4);
        do_op(1'b0, 1'b1, 32'd1040, 32'h0);
        rand_ops(40);
        idle(1);

        sel_fast  = 1'b1;
        exp_rdata = 32'd0;
        idle(2);
        do_op(1'b0, 1'b1, 32'd1024, 32'h0);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0);
        do_op(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0);
        rand_ops(25);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
